u_sequencer: RTL and testbench

U_SEQUENCER -- requirements
Module: u_sequencer

---
 rtl/u_seq_if.sv | 43 ++++
 rtl/u_sequencer.sv | 139 +++++++++++++
 tb/tb_u_sequencer.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/u_seq_if.sv
// Microsequencer bus: control-word fields, status inputs, and sequencer outputs.
// Ports: master drives control/status and samples outputs; slave is the sequencer.
interface u_seq_if #(
  parameter int UADDR_W = 15
);
  logic               u_en;
  logic [1:0]         typ;
  logic [6:0]         offset;
  logic               cond_invert;
  logic               cond_flag_src;
  logic [3:0]         cond_sel;
  logic               escape;
  logic [7:0]         ir;
  logic [3:0]         cpu_flags;
  logic [3:0]         u_flags;
  logic               irq_pending;
  logic               irq_en;
  logic               dma_req;
  logic               halt;
  logic [UADDR_W-1:0] uaddr;
  logic               cond_true;
  logic               int_ack;
  logic               dma_ack;
  logic               halted;

  modport master (
    output u_en, typ, offset, cond_invert,
    output cond_flag_src, cond_sel, escape, ir,
    output cpu_flags, u_flags, irq_pending,
    output irq_en, dma_req, halt,
    input  uaddr, cond_true, int_ack,
    input  dma_ack, halted
  );

  modport slave (
    input  u_en, typ, offset, cond_invert,
    input  cond_flag_src, cond_sel, escape, ir,
    input  cpu_flags, u_flags, irq_pending,
    input  irq_en, dma_req, halt,
    output uaddr, cond_true, int_ack,
    output dma_ack, halted
  );
endinterface

// File: rtl/u_sequencer.sv
// Microcode sequencer: next-microaddress logic, condition eval, RUN/DMA_HOLD/HALT.
// Ports: clk, arst_n (async low), s (u_seq_if.slave). DMA via U_SEQUENCER_DMA_EN.
module u_sequencer #(
  parameter int                 UADDR_W    = 15,
  parameter logic [UADDR_W-1:0] FETCH_ADDR = 15'h0000,
  parameter logic [UADDR_W-1:0] INT_ADDR   = 15'h0040
) (
  input  logic   clk,
  input  logic   arst_n,
  u_seq_if.slave s
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    DMA_HOLD = 2'd1,
    HALT     = 2'd2
  } state_t;

  state_t             state_q;
  logic [UADDR_W-1:0] uaddr_q;
  logic               int_ack_q;
  logic               dma_ack_q;
  logic               halted_q;

  logic [3:0]         flg;
  logic               raw;
  logic               cond;
  logic               dma_take;
  logic               irq_take;
  logic [UADDR_W-1:0] seq_d;
  logic [UADDR_W-1:0] rel_d;
  logic [UADDR_W-1:0] page_d;
  logic [UADDR_W-1:0] disp_d;

`ifdef U_SEQUENCER_DMA_EN
  assign dma_take = s.dma_req;
`else
  logic unused_dma_req;
  assign unused_dma_req = s.dma_req;
  assign dma_take = 1'b0;
`endif

  // flags packed {of,sf,cf,zf}
  always_comb begin
    flg = s.cond_flag_src ? s.u_flags : s.cpu_flags;
    raw = 1'b0;
    case (s.cond_sel)
      4'd0:    raw = flg[0];
      4'd1:    raw = flg[1];
      4'd2:    raw = flg[2];
      4'd3:    raw = flg[3];
      4'd4:    raw = flg[0] | flg[1];
      4'd5:    raw = flg[2] ^ flg[3];
      4'd6:    raw = (flg[2] ^ flg[3]) | flg[0];
      4'd7:    raw = 1'b1;
      4'd8:    raw = s.irq_pending & s.irq_en;
      default: raw = 1'b0;
    endcase
  end

  assign cond = raw ^ s.cond_invert;

  // Suppress back-to-back vectoring so int_ack never stretches.
  assign irq_take = s.irq_pending & s.irq_en & ~int_ack_q;

  assign seq_d  = uaddr_q + 1'b1;
  assign rel_d  = uaddr_q + {{(UADDR_W-7){s.offset[6]}}, s.offset};
  assign page_d = {uaddr_q[UADDR_W-1:6], s.offset[5:0]};
  assign disp_d = UADDR_W'({s.escape, s.ir, 6'b0});

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= RUN;
      uaddr_q   <= FETCH_ADDR;
      int_ack_q <= 1'b0;
      dma_ack_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      int_ack_q <= 1'b0;
      unique case (state_q)
        RUN: begin
          if (s.u_en) begin
            unique case (s.typ)
              2'b00: uaddr_q <= cond ? rel_d : seq_d;
              2'b01: uaddr_q <= cond ? page_d : seq_d;
              2'b10: uaddr_q <= disp_d;
              2'b11: begin
                uaddr_q <= FETCH_ADDR;
                if (dma_take) begin
                  state_q   <= DMA_HOLD;
                  dma_ack_q <= 1'b1;
                end else if (irq_take) begin
                  uaddr_q   <= INT_ADDR;
                  int_ack_q <= 1'b1;
                end else if (s.halt) begin
                  state_q  <= HALT;
                  halted_q <= 1'b1;
                end
              end
            endcase
          end
        end
        DMA_HOLD: begin
          uaddr_q <= FETCH_ADDR;
          if (!dma_take) begin
            state_q   <= RUN;
            dma_ack_q <= 1'b0;
          end
        end
        HALT: begin
          uaddr_q <= FETCH_ADDR;
          if (dma_take) begin
            state_q   <= DMA_HOLD;
            dma_ack_q <= 1'b1;
            halted_q  <= 1'b0;
          end else if (irq_take) begin
            state_q   <= RUN;
            uaddr_q   <= INT_ADDR;
            int_ack_q <= 1'b1;
            halted_q  <= 1'b0;
          end
        end
        default: begin
          state_q   <= RUN;
          uaddr_q   <= FETCH_ADDR;
          dma_ack_q <= 1'b0;
          halted_q  <= 1'b0;
        end
      endcase
    end
  end

  assign s.uaddr     = uaddr_q;
  assign s.cond_true = cond;
  assign s.int_ack   = int_ack_q;
  assign s.dma_ack   = dma_ack_q;
  assign s.halted    = halted_q;

endmodule

// File: tb/tb_u_sequencer.sv
// Scoreboard bench for u_sequencer: directed scenarios plus random traffic.
// Expected values come from an arithmetic reference model of the sequencer rules.
module tb_u_sequencer;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  u_seq_if #(.UADDR_W(15)) bus ();

  u_sequencer #(.UADDR_W(15)) dut (
    .clk    (clk),
    .arst_n (arst_n),
    .s      (bus)
  );

  typedef struct {
    bit cond;
    int ua;
    bit ia;
    bit da;
    bit hl;
  } exp_t;

  exp_t q[$];
  int ncmp = 0;
  int nerr = 0;

  // model: 0 run, 1 dma hold, 2 halt
  int m_st = 0;
  int m_ua = 0;
  bit m_ia = 0;

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    ncmp++;
    if (a !== e) begin
      nerr++;
      $display("FAIL %s got %0h want %0h", n, a, e);
    end
  endtask

  task automatic defaults();
    bus.u_en = 1; bus.typ = 0; bus.offset = 0;
    bus.cond_invert = 0; bus.cond_flag_src = 0;
    bus.cond_sel = 4'd9; bus.escape = 0; bus.ir = 0;
    bus.cpu_flags = 0; bus.u_flags = 0;
    bus.irq_pending = 0; bus.irq_en = 0;
    bus.dma_req = 0; bus.halt = 0;
  endtask

  function automatic bit eval_cond();
    logic [3:0] f;
    bit zf, cf, sf, of, r;
    f = bus.cond_flag_src ? bus.u_flags : bus.cpu_flags;
    zf = f[0]; cf = f[1]; sf = f[2]; of = f[3];
    case (int'(bus.cond_sel))
      0: r = zf;
      1: r = cf;
      2: r = sf;
      3: r = of;
      4: r = zf | cf;
      5: r = sf != of;
      6: r = (sf != of) | zf;
      7: r = 1;
      8: r = bus.irq_pending & bus.irq_en;
      default: r = 0;
    endcase
    return r ^ bus.cond_invert;
  endfunction

  // Apply current inputs for one clock, predicting the result.
  task automatic step();
    exp_t e;
    bit irq, dma, nia;
    int sx, off;
    irq = bus.irq_pending && bus.irq_en && !m_ia;
`ifdef U_SEQUENCER_DMA_EN
    dma = bus.dma_req;
`else
    dma = 0;
`endif
    e.cond = eval_cond();
    off = int'(bus.offset);
    nia = 0;
    if (m_st == 0) begin
      if (bus.u_en) begin
        case (int'(bus.typ))
          0: begin
            sx = (off >= 64) ? off - 128 : off;
            m_ua = e.cond ? (m_ua + sx + 32768) % 32768
                          : (m_ua + 1) % 32768;
          end
          1: m_ua = e.cond ? (m_ua / 64) * 64 + off % 64
                           : (m_ua + 1) % 32768;
          2: m_ua = int'(bus.escape) * 16384 + int'(bus.ir) * 64;
          default: begin
            m_ua = 0;
            if (dma) m_st = 1;
            else if (irq) begin m_ua = 'h40; nia = 1; end
            else if (bus.halt) m_st = 2;
          end
        endcase
      end
    end else if (m_st == 1) begin
      m_ua = 0;
      if (!dma) m_st = 0;
    end else begin
      m_ua = 0;
      if (dma) m_st = 1;
      else if (irq) begin m_st = 0; m_ua = 'h40; nia = 1; end
    end
    m_ia = nia;
    e.ua = m_ua; e.ia = m_ia;
    e.da = (m_st == 1); e.hl = (m_st == 2);
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Monitor: condition mid-cycle, registered outputs just after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        chk("cond_true", 32'(bus.cond_true), 32'(q[0].cond));
        @(posedge clk);
        #1;
        e = q.pop_front();
        chk("uaddr", 32'(bus.uaddr), 32'(e.ua));
        chk("int_ack", 32'(bus.int_ack), 32'(e.ia));
        chk("dma_ack", 32'(bus.dma_ack), 32'(e.da));
        chk("halted", 32'(bus.halted), 32'(e.hl));
      end
    end
  end

  task automatic chk_reset(string n);
    chk({n, "_uaddr"}, 32'(bus.uaddr), 32'h0);
    chk({n, "_int_ack"}, 32'(bus.int_ack), 32'h0);
    chk({n, "_dma_ack"}, 32'(bus.dma_ack), 32'h0);
    chk({n, "_halted"}, 32'(bus.halted), 32'h0);
  endtask

  // Async reset mid-cycle; u_en low at release so the first edge holds.
  task automatic async_rst(string n);
    #4;
    arst_n = 0;
    #1;
    chk_reset(n);
    m_st = 0; m_ua = 0; m_ia = 0;
    bus.u_en = 0;
    bus.dma_req = 0;
    @(negedge clk);
    arst_n = 1;
    @(posedge clk);
    #2;
    defaults();
  endtask

  initial begin
    defaults();
    bus.u_en = 0;
    #12;
    chk_reset("por");
    @(negedge clk);
    arst_n = 1;
    @(posedge clk);
    #2;
    defaults();

    // first advance uses FETCH_ADDR word
    step();
    chk("first_adv", 32'(bus.uaddr), 32'h1);

    // relative branch back and inverted
    bus.typ = 2; bus.ir = 8'h04; step();
    bus.typ = 0; bus.cond_sel = 7; bus.offset = 7'd5; step();
    chk("at_0105", 32'(bus.uaddr), 32'h105);
    bus.offset = 7'h7E; step();
    chk("rel_neg", 32'(bus.uaddr), 32'h103);
    bus.offset = 7'd2; step();
    bus.offset = 7'h7E; bus.cond_invert = 1; step();
    chk("rel_inv", 32'(bus.uaddr), 32'h106);
    bus.cond_invert = 0;

    // wrap at top of space
    bus.typ = 2; bus.escape = 1; bus.ir = 8'hFF; step();
    bus.typ = 1; bus.offset = 7'h3F; step();
    chk("at_7fff", 32'(bus.uaddr), 32'h7FFF);
    bus.typ = 0; bus.cond_sel = 9; step();
    chk("wrap", 32'(bus.uaddr), 32'h0);

    // dispatch with/without escape
    bus.typ = 2; bus.ir = 8'h3A; bus.escape = 1; step();
    chk("disp_esc", 32'(bus.uaddr), 32'h4E80);
    bus.escape = 0; step();
    chk("disp_noesc", 32'(bus.uaddr), 32'h0E80);

    // wait states
    bus.ir = 8'h04; step();
    bus.typ = 1; bus.cond_sel = 7; bus.offset = 7'h23; step();
    bus.typ = 0; bus.offset = 7'd5; bus.u_en = 0;
    repeat (5) step();
    chk("wait_hold", 32'(bus.uaddr), 32'h123);
    defaults();

    // boundary with dma and irq both pending
    bus.typ = 3; bus.irq_pending = 1; bus.irq_en = 1; bus.dma_req = 1;
    step();
`ifdef U_SEQUENCER_DMA_EN
    chk("dma_ack_on", 32'(bus.dma_ack), 32'h1);
    repeat (3) begin bus.u_en = 1'($urandom); step(); end
    bus.u_en = 1; bus.dma_req = 0; step();
    chk("dma_exit_ua", 32'(bus.uaddr), 32'h0);
    chk("dma_ack_off", 32'(bus.dma_ack), 32'h0);
    step();
`else
    chk("nodma_ack", 32'(bus.dma_ack), 32'h0);
`endif
    chk("irq_vec", 32'(bus.uaddr), 32'h40);
    chk("irq_ack", 32'(bus.int_ack), 32'h1);
    bus.dma_req = 0; step();
    chk("irq_ack_1cyc", 32'(bus.int_ack), 32'h0);
    defaults();

    // halt, hold 20 cycles, exit by irq
    bus.typ = 3; bus.halt = 1; step();
    chk("halted_on", 32'(bus.halted), 32'h1);
    bus.halt = 0;
    for (int i = 0; i < 20; i++) begin
      bus.typ = 2'($urandom); bus.u_en = 1'($urandom);
      bus.ir = 8'($urandom); step();
    end
    chk("halt_hold", 32'(bus.uaddr), 32'h0);
    chk("halt_still", 32'(bus.halted), 32'h1);
    bus.irq_pending = 1; bus.irq_en = 1; step();
    chk("halt_irq_ua", 32'(bus.uaddr), 32'h40);
    chk("halt_irq_hl", 32'(bus.halted), 32'h0);
    chk("halt_irq_ack", 32'(bus.int_ack), 32'h1);
    bus.typ = 3; step();
    chk("no_dbl_ack", 32'(bus.int_ack), 32'h0);
    defaults();

    // reset while parked (DMA_HOLD when present, else HALT)
`ifdef U_SEQUENCER_DMA_EN
    bus.typ = 3; bus.dma_req = 1; step();
    chk("pre_rst_dma", 32'(bus.dma_ack), 32'h1);
`else
    bus.typ = 3; bus.halt = 1; step();
    chk("pre_rst_halt", 32'(bus.halted), 32'h1);
`endif
    async_rst("rst_park");

    // random traffic
    for (int i = 0; i < 1500; i++) begin
      bus.u_en = ($urandom_range(3) != 0);
      bus.typ = 2'($urandom);
      bus.offset = 7'($urandom);
      bus.cond_invert = 1'($urandom);
      bus.cond_flag_src = 1'($urandom);
      bus.cond_sel = 4'($urandom);
      bus.escape = 1'($urandom);
      bus.ir = 8'($urandom);
      bus.cpu_flags = 4'($urandom);
      bus.u_flags = 4'($urandom);
      bus.irq_pending = ($urandom_range(3) == 0);
      bus.irq_en = 1'($urandom);
      bus.dma_req = ($urandom_range(15) == 0);
      bus.halt = ($urandom_range(15) == 0);
      step();
      if (i == 700) async_rst("rst_rand");
    end

    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d want 0", q.size());
    end
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
